// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
// Holds op encodings, FSM state type and the divide-by-zero quotient.
// Helpers classify an op as signed and/or divide.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FINAL = 2'd2
  } state_t;

  // Quotient reported for any division by zero (no trap is raised).
  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

  function automatic logic op_is_signed(input logic [1:0] op_v);
    return (op_v == OP_MULT) || (op_v == OP_DIV);
  endfunction

  function automatic logic op_is_div(input logic [1:0] op_v);
    return (op_v == OP_DIV) || (op_v == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide.
// Latency: purely combinational, no state.
// Backpressure: none; the caller decides when to register acc_nxt.
//
// Ports:
//   acc      : 2*WIDTH+1 accumulator. Multiply: {0, partial hi, multiplier
//              bits still to consume}. Divide: {partial remainder, dividend
//              bits / quotient bits}.
//   opnd     : multiplicand (multiply) or divisor (divide), unsigned magnitude.
//   mode_div : 1 = divide step, 0 = multiply step.
//   acc_nxt  : accumulator after this iteration.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0]   acc,
  input  logic [WIDTH-1:0]   opnd,
  input  logic               mode_div,
  output logic [2*WIDTH:0]   acc_nxt
);

  logic [WIDTH:0]   mul_sum;
  logic [2*WIDTH:0] div_sh;
  logic [WIDTH:0]   div_trial;
  logic             div_fits;
  logic             unused_acc_msb;

  // The top bit of the accumulator is always zero on entry: the multiply
  // path keeps it clear and the divide remainder never reaches 2^WIDTH.
  assign unused_acc_msb = acc[2*WIDTH];

  // Multiply: add multiplicand into the upper half when the current
  // multiplier LSB is set, then shift the whole accumulator right.
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);

  // Divide: shift next dividend bit into the remainder and try subtracting.
  assign div_sh    = {acc[2*WIDTH-1:0], 1'b0};
  assign div_fits  = div_sh[2*WIDTH:WIDTH] >= {1'b0, opnd};
  assign div_trial = div_sh[2*WIDTH:WIDTH] - {1'b0, opnd};

  always_comb begin
    acc_nxt = '0;
    if (mode_div) begin
      if (div_fits) begin
        acc_nxt = {div_trial, div_sh[WIDTH-1:1], 1'b1};
      end else begin
        acc_nxt = div_sh;
      end
    end else begin
      acc_nxt = {1'b0, mul_sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/ula_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the HI/LO registers.
// Latency: start sampled at E0, busy for 33 cycles, HI/LO written at E33.
// Backpressure: busy stalls the pipeline; start/mthi/mtlo ignored while busy.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset.
//   start, op  : begin an operation (00 MULT, 01 MULTU, 10 DIV, 11 DIVU).
//   ln1, ln2   : multiplicand/dividend and multiplier/divisor; ln1 is also
//                the data for mthi/mtlo.
//   mthi, mtlo : write ln1 into HI / LO while idle.
//   busy, done : operation in progress / one-cycle result-written pulse.
//   hi, lo     : HI and LO registers.
module ula_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] ln1,
  input  logic [WIDTH-1:0] ln2,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int AW = 2 * WIDTH + 1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [1:0]       op_q,    op_d;
  logic             sa_q,    sa_d;
  logic             sb_q,    sb_d;
  logic [AW-1:0]    acc_q,   acc_d;
  logic [WIDTH-1:0] opnd_q,  opnd_d;
  logic [WIDTH-1:0] hi_q,    hi_d;
  logic [WIDTH-1:0] lo_q,    lo_d;
  logic             done_q,  done_d;

  // Operand signs and magnitudes at issue. Negating INT_MIN yields the same
  // bit pattern, which read as unsigned is exactly 2^(WIDTH-1).
  logic             in_signed, in_div, sgn_a, sgn_b;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign in_signed = op_is_signed(op);
  assign in_div    = op_is_div(op);
  assign sgn_a     = in_signed & ln1[WIDTH-1];
  assign sgn_b     = in_signed & ln2[WIDTH-1];
  assign mag_a     = sgn_a ? -ln1 : ln1;
  assign mag_b     = sgn_b ? -ln2 : ln2;

  logic [AW-1:0] acc_step;

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc      (acc_q),
    .opnd     (opnd_q),
    .mode_div (op_is_div(op_q)),
    .acc_nxt  (acc_step)
  );

  // Sign fix-up of the finished magnitudes.
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo, quo_fix, rem, rem_fix;
  logic               div_by_zero;
  logic               unused_acc_msb;

  assign unused_acc_msb = acc_q[AW-1];
  assign prod        = acc_q[2*WIDTH-1:0];
  assign prod_fix    = (sa_q ^ sb_q) ? -prod : prod;
  assign quo         = acc_q[WIDTH-1:0];
  assign rem         = acc_q[2*WIDTH-1:WIDTH];
  assign quo_fix     = (sa_q ^ sb_q) ? -quo : quo;
  assign rem_fix     = sa_q ? -rem : rem;
  // With a zero divisor every trial subtraction succeeds, so the remainder
  // rebuilds the dividend magnitude; rem_fix therefore returns ln1 as issued.
  assign div_by_zero = (opnd_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // start takes priority; simultaneous moves are dropped.
          state_d = ST_CALC;
          op_d    = op;
          sa_d    = sgn_a;
          sb_d    = sgn_b;
          cnt_d   = '0;
          // Low half of the accumulator holds the bits consumed one per
          // step: the multiplier for MULT, the dividend for DIV.
          acc_d   = {{(WIDTH + 1){1'b0}}, (in_div ? mag_a : mag_b)};
          opnd_d  = in_div ? mag_b : mag_a;
        end else begin
          if (mthi) hi_d = ln1;
          if (mtlo) lo_d = ln1;
        end
      end

      ST_CALC: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_FINAL;
        end
      end

      ST_FINAL: begin
        if (op_is_div(op_q)) begin
          hi_d = rem_fix;
          lo_d = div_by_zero ? WIDTH'(DIV0_LO) : quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      acc_q   <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_ula_muldiv.sv
// Self-checking bench for ula_muldiv: vector table plus scoreboard queue.
// Expected {hi,lo} pushed when start is driven, popped when done pulses.
// Corner sequences: moves, ignored start/mtlo while busy, mid-op reset.
module tb_ula_muldiv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] ln1 = '0;
  logic [31:0] ln2 = '0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb_q[$];

  ula_muldiv #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .ln1   (ln1),
    .ln2   (ln2),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Independent reference built on the simulator's own arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] pa, pb, ps;
    logic signed [31:0] da, db;
    logic [63:0] r;
    r = '0;
    case (o)
      2'b00: begin
        pa = {{32{a[31]}}, a};
        pb = {{32{b[31]}}, b};
        ps = pa * pb;
        r  = ps;
      end
      2'b01: r = {32'b0, a} * {32'b0, b};
      2'b10: begin
        da = a;
        db = b;
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
        else r = {32'(da % db), 32'(da / db)};
      end
      default: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  // Issue one op and return in the cycle done is seen (so the next call
  // issues back-to-back). disturb: pulse start+mtlo mid-op; with_mv: assert
  // mthi/mtlo together with start.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp,
                        input bit disturb, input bit with_mv);
    logic [31:0] ph, pl;
    logic [63:0] e;
    int bc, guard;
    bit held;
    ph = hi;
    pl = lo;
    op = o; ln1 = a; ln2 = b; start = 1'b1; mthi = with_mv; mtlo = with_mv;
    sb_q.push_back(exp);
    tick;
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    ln1 = $urandom; ln2 = $urandom;
    chk({tag, " done_low_after_start"}, {63'b0, done}, 64'd0);
    bc = 0; guard = 0; held = 1'b1;
    while (!done && guard < 100) begin
      if (busy) begin
        bc++;
        if (hi !== ph || lo !== pl) held = 1'b0;
      end
      if (disturb && bc == 5) begin
        start = 1'b1; mtlo = 1'b1; op = 2'b11; ln1 = 32'h1234_5678; ln2 = 32'd1;
      end else begin
        start = 1'b0; mtlo = 1'b0;
      end
      tick;
      guard++;
    end
    start = 1'b0; mtlo = 1'b0;
    chk({tag, " done_seen"}, {63'b0, done}, 64'd1);
    chk({tag, " busy_cycles"}, 64'(bc), 64'd33);
    chk({tag, " hold_during_calc"}, {63'b0, held}, 64'd1);
    chk({tag, " busy_fall"}, {63'b0, busy}, 64'd0);
    if (done) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL %s unexpected_done: got done with no pending result required none", tag);
      end else begin
        e = sb_q.pop_front();
        chk({tag, " hi"}, {32'b0, hi}, {32'b0, e[63:32]});
        chk({tag, " lo"}, {32'b0, lo}, {32'b0, e[31:0]});
      end
    end else begin
      sb_q.delete();
    end
  endtask

  initial begin
    bit seen_done;
    logic [31:0] ra, rb;
    logic [1:0]  ro;

    vecs[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1]  = '{2'b00, 32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2]  = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[3]  = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4]  = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[5]  = '{2'b11, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
    vecs[6]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[7]  = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[8]  = '{2'b10, 32'hFFFF_FFF7, 32'd0,         32'hFFFF_FFF7, 32'hFFFF_FFFF};
    vecs[9]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[10] = '{2'b01, 32'h8000_0000, 32'd2,         32'h0000_0001, 32'h0000_0000};
    vecs[11] = '{2'b11, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 32'hFFFF_FFFF};
    vecs[12] = '{2'b10, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd14};
    vecs[13] = '{2'b00, 32'd12345,     32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_CFC7};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("reset hi",   {32'b0, hi}, 64'd0);
    chk("reset lo",   {32'b0, lo}, 64'd0);
    chk("reset busy", {63'b0, busy}, 64'd0);
    chk("reset done", {63'b0, done}, 64'd0);
    rst_n = 1'b1;
    tick;

    // Moves while idle.
    ln1 = 32'hA5A5_A5A5; mthi = 1'b1;
    tick;
    mthi = 1'b0;
    chk("mthi hi", {32'b0, hi}, {32'b0, 32'hA5A5_A5A5});
    chk("mthi lo_untouched", {32'b0, lo}, 64'd0);
    ln1 = 32'h3C3C_3C3C; mthi = 1'b1; mtlo = 1'b1;
    tick;
    mthi = 1'b0; mtlo = 1'b0;
    chk("mthi_mtlo hi", {32'b0, hi}, {32'b0, 32'h3C3C_3C3C});
    chk("mthi_mtlo lo", {32'b0, lo}, {32'b0, 32'h3C3C_3C3C});

    // Table vectors, issued back-to-back. Vector 1 is disturbed mid-op,
    // vector 2 carries moves alongside start.
    for (int i = 0; i < 14; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             {vecs[i].hi, vecs[i].lo}, (i == 1), (i == 2));
    end

    // Random operations against the reference model.
    for (int i = 0; i < 6; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 5) ? 32'd0 : $urandom;
      if (i == 3) rb = rb >> 20;
      run_op($sformatf("rnd%0d", i), ro, ra, rb, model(ro, ra, rb), 1'b0, 1'b0);
    end

    // Mid-operation reset.
    tick;
    ln1 = 32'hDEAD_BEEF; mthi = 1'b1; mtlo = 1'b1;
    tick;
    mthi = 1'b0; mtlo = 1'b0;
    op = 2'b10; ln1 = 32'hFFFF_FF00; ln2 = 32'd3; start = 1'b1;
    sb_q.push_back(model(2'b10, 32'hFFFF_FF00, 32'd3));
    tick;
    start = 1'b0;
    repeat (9) tick;
    chk("pre_reset busy", {63'b0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midreset busy", {63'b0, busy}, 64'd0);
    chk("midreset hi",   {32'b0, hi}, 64'd0);
    chk("midreset lo",   {32'b0, lo}, 64'd0);
    chk("midreset done", {63'b0, done}, 64'd0);
    sb_q.delete();
    #1;
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (done || busy) seen_done = 1'b1;
    end
    chk("after_reset no_done", {63'b0, seen_done}, 64'd0);
    run_op("post_reset multu", 2'b01, 32'd6, 32'd7, {32'd0, 32'd42}, 1'b0, 1'b0);

    tick;
    chk("final done_cleared", {63'b0, done}, 64'd0);
    chk("scoreboard empty", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ula_muldiv.md
# ula_muldiv

Iterative multiply/divide unit for the MIPS datapath, sitting in the execute stage beside the ULA and fed by the same `ln1`/`ln2` operand buses from the register file. It executes MULT, MULTU, DIV and DIVU over multiple cycles and holds the HI/LO results. Its `busy` flag drives the processor's stall logic, and its `hi`/`lo` outputs feed the writeback mux for MFHI/MFLO. MTHI/MTLO write those registers directly.

## Interface
Parameters:
- `WIDTH`, 32: operand and HI/LO width.
- `CNT_W`, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports (clock and reset are one clock domain; reset is asynchronous and active-low):
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request to begin an operation; sampled only while idle.
- `op` input 2: operation select. 00 = MULT, 01 = MULTU, 10 = DIV, 11 = DIVU.
- `ln1` input WIDTH: multiplicand / dividend; also the data for MTHI/MTLO.
- `ln2` input WIDTH: multiplier / divisor.
- `mthi` input 1: write `ln1` into HI.
- `mtlo` input 1: write `ln1` into LO.
- `busy` output 1: operation in progress; stall request.
- `done` output 1: one-cycle pulse when HI/LO have just been updated by an operation.
- `hi` output WIDTH: HI register.
- `lo` output WIDTH: LO register.

## Operation
- FSM states and transitions:
  - IDLE: `start` -> CALC. On that edge, latch `op`, the magnitudes of `ln1`/`ln2` (signed ops only), and both operand signs; clear the counter.
  - CALC: one radix-2 step per cycle for WIDTH cycles, then -> FINAL.
  - FINAL: apply sign fix-up, write HI/LO, -> IDLE.
- Multiply step: shift-add into a 2·WIDTH accumulator.
  - Result: HI = upper WIDTH bits, LO = lower WIDTH bits.
  - Signed: negate the 2·WIDTH product when operand signs differ.
- Divide step: restoring division.
  - Result: LO = quotient, HI = remainder.
  - Signed: quotient truncates toward zero and is negated when operand signs differ; remainder takes the sign of the dividend.
- Divide by zero: no trap. HI = `ln1` as latched, LO = 32'hFFFFFFFF, normal latency.
- DIV 32'h80000000 / 32'hFFFFFFFF: LO = 32'h80000000, HI = 0.
- Magnitude of INT_MIN: handled as the unsigned value 2^31, with no overflow in the internal path.
- `start` while busy: ignored.
- `mthi`/`mtlo` while busy: ignored.
- `mthi`/`mtlo` while idle: the register is written at the next edge.
- `start` together with `mthi`/`mtlo` while idle: `start` wins and the moves are dropped.
- `mthi` together with `mtlo`: both registers are written.

## Timing
- Reset values: `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0, state = IDLE, counter = 0.
- Reset asserted mid-operation: immediate return to IDLE with all outputs at reset values; the operation is discarded.
- Latency:
  - `start` is sampled at edge E0.
  - `busy` is high from after E0 through E33 (33 cycles).
  - HI/LO update at E33.
  - `done` is high for the single cycle after E33, which is the same cycle `busy` falls.
- Back-to-back: a new `start` is accepted in the cycle `done` is high, since the FSM is already in IDLE.
- `hi`/`lo` are registered and hold their values during CALC. Only FINAL, `mthi`/`mtlo`, or reset may change them.
- No combinational path from any input to any output.

## Structure
- Package `muldiv_pkg`:
  - op encodings: `OP_MULT`, `OP_MULTU`, `OP_DIV`, `OP_DIVU`.
  - FSM state typedef: `ST_IDLE`, `ST_CALC`, `ST_FINAL`.
  - constant `DIV0_LO` = 32'hFFFFFFFF.
- Sub-module `muldiv_step`: combinational single-iteration datapath.
  - Inputs: accumulator, operand register, mode (mul/div).
  - Output: next accumulator.
  - The top level holds the FSM, counter, sign registers, and HI/LO.

## Test plan
- MULTU 32'hFFFFFFFF × 32'hFFFFFFFF -> after 33 busy cycles, HI = 32'hFFFFFFFE, LO = 32'h00000001, `done` pulses once.
- MULT -7 × 3 -> HI = 32'hFFFFFFFF, LO = 32'hFFFFFFEB. Also check INT_MIN × -1 -> HI = 0, LO = 32'h80000000.
- DIV -7 / 2 -> LO = 32'hFFFFFFFD, HI = 32'hFFFFFFFF. DIVU 100 / 7 -> LO = 14, HI = 2.
- DIVU 5 / 0 -> HI = 5, LO = 32'hFFFFFFFF. DIV 32'h80000000 / -1 -> LO = 32'h80000000, HI = 0.
- `mthi` with `ln1` = 32'hA5A5A5A5 while idle -> `hi` updates next edge. `mtlo` and a second `start` during an operation -> both ignored; the result matches the first operation only.
- `rst_n` pulsed low at cycle 10 of a DIV -> `busy`/`hi`/`lo` = 0 immediately, no `done`. A fresh MULTU 6 × 7 then yields LO = 42.
